// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback plus a queued
// accelerator result path, with WAW kill, hazard reporting and forced drain.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_we,
  input  logic [REG_AW-1:0]          pipe_rd,
  input  logic [DATA_W-1:0]          pipe_data,
  input  logic                       acc_valid,
  input  logic [REG_AW-1:0]          acc_rd,
  input  logic [DATA_W-1:0]          acc_data,
  output logic                       acc_ready,
  input  logic [REG_AW-1:0]          rs,
  input  logic [REG_AW-1:0]          rt,
  output logic                       hit_rs,
  output logic                       hit_rt,
  output logic                       pipe_stall,
  output logic                       regWrite,
  output logic [REG_AW-1:0]          rd,
  output logic [DATA_W-1:0]          write_data,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [REG_AW-1:0] ent_rd_q   [DEPTH];
  logic [REG_AW-1:0] ent_rd_d   [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic [DEPTH-1:0]  ent_kill_q, ent_kill_d;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              pipe_acc;
  logic              push;
  logic              pop;
  logic              nonempty;

  assign nonempty   = (count_q != '0);
  assign acc_ready  = (count_q < CW'(DEPTH));
  assign pipe_stall = (starve_q == SW'(STARVE_MAX));
  assign pipe_acc   = pipe_we & ~pipe_stall;
  assign push       = acc_valid & acc_ready;
  assign pop        = ~pipe_acc & nonempty;

  assign regWrite   = we_q;
  assign rd         = rd_q;
  assign write_data = wd_q;
  assign fifo_count = count_q;

  // Queue storage; an accepted pipe write kills matching entries,
  // including one entering in the same cycle.
  always_comb begin
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    ent_kill_d = ent_kill_q;
    if (pipe_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_rd_q[i] == pipe_rd) ent_kill_d[i] = 1'b1;
      end
    end
    if (push) begin
      ent_rd_d[tail_q]   = acc_rd;
      ent_data_d[tail_q] = acc_data;
      ent_kill_d[tail_q] = pipe_acc & (acc_rd == pipe_rd);
    end
  end

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    if (!nonempty || pop) begin
      starve_d = '0;
    end else if (pipe_stall) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    we_d = 1'b0;
    rd_d = rd_q;
    wd_d = wd_q;
    unique case (1'b1)
      pipe_acc: begin
        we_d = 1'b1;
        rd_d = pipe_rd;
        wd_d = pipe_data;
      end
      pop: begin
        we_d = ~ent_kill_q[head_q];
        rd_d = ent_rd_q[head_q];
        wd_d = ent_data_q[head_q];
      end
      default: ;
    endcase
  end

  // Popped entries have left the queue, so the write on the port is never hit.
  always_comb begin
    logic [PW-1:0] off;
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if ({1'b0, off} < count_q && !ent_kill_q[i]) begin
        if (ent_rd_q[i] == rs) hit_rs = 1'b1;
        if (ent_rd_q[i] == rt) hit_rt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
      ent_kill_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
    end else begin
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      ent_kill_q <= ent_kill_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
    end
  end

endmodule
